// File: rtl/nand_bus_cycle_gen.sv
// -----------------------------------------------------------------------------
// nand_bus_cycle_gen
// Bus-cycle engine sitting below the NAND controller sequencing FSM. The FSM
// hands over one primitive op per handshake (command latch, address latch,
// data write, data read, wait-for-ready). This block produces the timed
// CLE/ALE/WE#/RE#/IO pin sequence, watches R/B#, and reports completion,
// read data and timeout/error status.
//
// Ports:
//   clk         system clock
//   reset_l     asynchronous active-low reset
//   op_valid    op request;          op_ready  high only when idle
//   op_code     0 CMD,1 ADDR,2 WDATA,3 RDATA,4 WAIT_RB (5-7 invalid)
//   op_byte     cmd/addr/data byte, captured at accept
//   op_done     one-cycle completion pulse
//   op_rdata    byte read by the last RDATA op
//   op_timeout  with op_done: WAIT_RB expired
//   op_error    with op_done: invalid op_code
//   ce_en/ce_l  chip enable request / registered active-low pin
//   cle, ale    latch enables;       we_l, re_l  active-low strobes
//   io_out/io_oe/io_in  IO pin drive value, enable and input
//   rb_l        ready/busy# pin (asynchronous, synchronised here)
// -----------------------------------------------------------------------------
module nand_bus_cycle_gen #(
    parameter int T_SETUP    = 1,
    parameter int T_WP       = 1,
    parameter int T_WH       = 1,
    parameter int T_RP       = 1,
    parameter int T_REH      = 1,
    parameter int T_WB       = 5,
    parameter int RB_TIMEOUT = 49999
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_byte,
    output logic       op_done,
    output logic [7:0] op_rdata,
    output logic       op_timeout,
    output logic       op_error,
    input  logic       ce_en,
    output logic       ce_l,
    output logic       cle,
    output logic       ale,
    output logic       we_l,
    output logic       re_l,
    output logic [7:0] io_out,
    output logic       io_oe,
    input  logic [7:0] io_in,
    input  logic       rb_l
);

    localparam logic [2:0] OP_CMD   = 3'd0;
    localparam logic [2:0] OP_ADDR  = 3'd1;
    localparam logic [2:0] OP_WDATA = 3'd2;
    localparam logic [2:0] OP_RDATA = 3'd3;
    localparam logic [2:0] OP_WAIT  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_WE_LO, S_WE_HI, S_RE_LO, S_RE_HI, S_WB, S_RB, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_code;
    logic [7:0]  r_byte;
    logic        r_op_ready;
    logic        r_rb_meta;
    logic        r_rb_sync;
    logic        r_cle, r_ale, r_we_l, r_re_l, r_io_oe, r_ce_l;
    logic [7:0]  r_io_out;
    logic        r_op_done, r_op_timeout, r_op_error;
    logic [7:0]  r_op_rdata;

    logic        w_accept;
    logic [2:0]  w_code_next;
    logic [7:0]  w_byte_next;
    logic        w_cnt_zero;
    logic        w_timeout_next;
    logic        w_write_phase;

    assign w_accept    = op_valid & r_op_ready;
    assign w_code_next = w_accept ? op_code : r_code;
    assign w_byte_next = w_accept ? op_byte : r_byte;
    assign w_cnt_zero  = (r_cnt == 16'd0);

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_timeout_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_code)
                        OP_CMD, OP_ADDR, OP_WDATA: w_state_next = S_SETUP;
                        OP_RDATA:                  w_state_next = S_RE_LO;
                        OP_WAIT:                   w_state_next = S_WB;
                        default:                   w_state_next = S_DONE;
                    endcase
                end
            end
            S_SETUP: if (w_cnt_zero) w_state_next = S_WE_LO;
            S_WE_LO: if (w_cnt_zero) w_state_next = S_WE_HI;
            S_WE_HI: if (w_cnt_zero) w_state_next = S_DONE;
            S_RE_LO: if (w_cnt_zero) w_state_next = S_RE_HI;
            S_RE_HI: if (w_cnt_zero) w_state_next = S_DONE;
            S_WB:    if (w_cnt_zero) w_state_next = S_RB;
            S_RB: begin
                // Ready wins over a simultaneous expiry.
                if (r_rb_sync) begin
                    w_state_next = S_DONE;
                end else if (w_cnt_zero) begin
                    w_state_next   = S_DONE;
                    w_timeout_next = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counter loads (duration - 1) on entry to a timed state, so a state
    // lasts exactly its parameter in cycles and exits when the count is 0.
    always_comb begin
        w_cnt_next = w_cnt_zero ? 16'd0 : (r_cnt - 16'd1);
        if (w_state_next != r_state) begin
            case (w_state_next)
                S_SETUP: w_cnt_next = 16'(T_SETUP - 1);
                S_WE_LO: w_cnt_next = 16'(T_WP - 1);
                S_WE_HI: w_cnt_next = 16'(T_WH - 1);
                S_RE_LO: w_cnt_next = 16'(T_RP - 1);
                S_RE_HI: w_cnt_next = 16'(T_REH - 1);
                S_WB:    w_cnt_next = 16'(T_WB - 1);
                S_RB:    w_cnt_next = 16'(RB_TIMEOUT - 1);
                default: w_cnt_next = 16'd0;
            endcase
        end
    end

    assign w_write_phase = (w_state_next == S_SETUP) || (w_state_next == S_WE_LO) ||
                           (w_state_next == S_WE_HI);

    // Pins are registered from the next-state decode so they are glitch-free
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_code       <= 3'd0;
            r_byte       <= 8'd0;
            r_op_ready   <= 1'b0;
            r_rb_meta    <= 1'b0;
            r_rb_sync    <= 1'b0;
            r_cle        <= 1'b0;
            r_ale        <= 1'b0;
            r_we_l       <= 1'b1;
            r_re_l       <= 1'b1;
            r_io_oe      <= 1'b0;
            r_io_out     <= 8'd0;
            r_ce_l       <= 1'b1;
            r_op_done    <= 1'b0;
            r_op_timeout <= 1'b0;
            r_op_error   <= 1'b0;
            r_op_rdata   <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_code       <= w_code_next;
            r_byte       <= w_byte_next;
            r_op_ready   <= (w_state_next == S_IDLE);
            r_rb_meta    <= rb_l;
            r_rb_sync    <= r_rb_meta;
            r_cle        <= w_write_phase && (w_code_next == OP_CMD);
            r_ale        <= w_write_phase && (w_code_next == OP_ADDR);
            r_we_l       <= (w_state_next != S_WE_LO);
            r_re_l       <= (w_state_next != S_RE_LO);
            r_io_oe      <= w_write_phase;
            r_io_out     <= w_write_phase ? w_byte_next : 8'd0;
            r_ce_l       <= ~ce_en;
            r_op_done    <= (w_state_next == S_DONE);
            r_op_timeout <= w_timeout_next;
            // The only direct IDLE->DONE path is an invalid op code.
            r_op_error   <= (r_state == S_IDLE) && (w_state_next == S_DONE);
            if ((r_state == S_RE_LO) && w_cnt_zero)
                r_op_rdata <= io_in;
        end
    end

    assign op_ready   = r_op_ready;
    assign op_done    = r_op_done;
    assign op_rdata   = r_op_rdata;
    assign op_timeout = r_op_timeout;
    assign op_error   = r_op_error;
    assign ce_l       = r_ce_l;
    assign cle        = r_cle;
    assign ale        = r_ale;
    assign we_l       = r_we_l;
    assign re_l       = r_re_l;
    assign io_out     = r_io_out;
    assign io_oe      = r_io_oe;

endmodule

// File: tb/tb_nand_bus_cycle_gen.sv
// -----------------------------------------------------------------------------
// tb_nand_bus_cycle_gen
// Directed bench for nand_bus_cycle_gen. Two instances share the stimulus:
// dut_a uses default pin timing, dut_b uses T_SETUP=2/T_WP=3. Both use a
// short RB_TIMEOUT of 100. Cycle numbers count from the accept edge: the cycle
// right after the accepting edge is cycle 1.
// -----------------------------------------------------------------------------
module tb_nand_bus_cycle_gen;

    logic       clk = 1'b0;
    logic       reset_l = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] op_byte = 8'd0;
    logic       ce_en = 1'b0;
    logic [7:0] io_in = 8'd0;
    logic       rb_l = 1'b1;

    logic       a_op_ready, a_op_done, a_op_timeout, a_op_error, a_ce_l;
    logic       a_cle, a_ale, a_we_l, a_re_l, a_io_oe;
    logic [7:0] a_op_rdata, a_io_out;
    logic       b_op_ready, b_op_done, b_op_timeout, b_op_error, b_ce_l;
    logic       b_cle, b_ale, b_we_l, b_re_l, b_io_oe;
    logic [7:0] b_op_rdata, b_io_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    nand_bus_cycle_gen #(.RB_TIMEOUT(100)) dut_a (
        .clk(clk), .reset_l(reset_l), .op_valid(op_valid), .op_ready(a_op_ready),
        .op_code(op_code), .op_byte(op_byte), .op_done(a_op_done),
        .op_rdata(a_op_rdata), .op_timeout(a_op_timeout), .op_error(a_op_error),
        .ce_en(ce_en), .ce_l(a_ce_l), .cle(a_cle), .ale(a_ale), .we_l(a_we_l),
        .re_l(a_re_l), .io_out(a_io_out), .io_oe(a_io_oe), .io_in(io_in), .rb_l(rb_l)
    );

    nand_bus_cycle_gen #(.T_SETUP(2), .T_WP(3), .RB_TIMEOUT(100)) dut_b (
        .clk(clk), .reset_l(reset_l), .op_valid(op_valid), .op_ready(b_op_ready),
        .op_code(op_code), .op_byte(op_byte), .op_done(b_op_done),
        .op_rdata(b_op_rdata), .op_timeout(b_op_timeout), .op_error(b_op_error),
        .ce_en(ce_en), .ce_l(b_ce_l), .cle(b_cle), .ale(b_ale), .we_l(b_we_l),
        .re_l(b_re_l), .io_out(b_io_out), .io_oe(b_io_oe), .io_in(io_in), .rb_l(rb_l)
    );

    // Present one op for the accept edge; returns #1 into cycle 1.
    task automatic issue(input logic [2:0] code, input logic [7:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_byte  = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (!(a_op_ready && b_op_ready) && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_checks++;
        if (!(a_op_ready && b_op_ready)) begin
            n_fail++;
            $display("FAIL idle_wait: ready a=%b b=%b, required both 1", a_op_ready, b_op_ready);
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        #1;
        n_checks++;
        if (a_we_l !== 1'b1 || a_re_l !== 1'b1 || a_ce_l !== 1'b1 || a_cle !== 1'b0 ||
            a_ale !== 1'b0 || a_io_oe !== 1'b0 || a_io_out !== 8'h00 || a_op_done !== 1'b0 ||
            a_op_timeout !== 1'b0 || a_op_error !== 1'b0 || a_op_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pins: we=%b re=%b ce=%b cle=%b ale=%b oe=%b io=%h done=%b to=%b err=%b rd=%h, required 1 1 1 0 0 0 00 0 0 0 00",
                     a_we_l, a_re_l, a_ce_l, a_cle, a_ale, a_io_oe, a_io_out, a_op_done,
                     a_op_timeout, a_op_error, a_op_rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: op_ready=%b, required 1", a_op_ready);
        end
        $display("reset: done");
    endtask

    task automatic test_cmd();
        logic exp_cle, exp_we, exp_done;
        wait_idle();
        issue(3'd0, 8'hFF);
        for (int c = 1; c <= 6; c++) begin
            exp_cle  = (c <= 3);
            exp_we   = (c != 2);
            exp_done = (c == 4);
            n_checks++;
            if (a_cle !== exp_cle || a_io_oe !== exp_cle || a_ale !== 1'b0 ||
                a_we_l !== exp_we || a_op_done !== exp_done ||
                (exp_cle && a_io_out !== 8'hFF)) begin
                n_fail++;
                $display("FAIL cmd c%0d: cle=%b oe=%b ale=%b we_l=%b done=%b io=%h, required cle=%b oe=%b ale=0 we_l=%b done=%b io=FF",
                         c, a_cle, a_io_oe, a_ale, a_we_l, a_op_done, a_io_out,
                         exp_cle, exp_cle, exp_we, exp_done);
            end
            @(posedge clk);
            #1;
        end
        $display("cmd: CMD 0xFF sequence checked");
    endtask

    task automatic test_addr();
        logic exp_ale, exp_we, exp_done;
        wait_idle();
        issue(3'd1, 8'h3A);
        for (int c = 1; c <= 8; c++) begin
            exp_ale  = (c <= 6);
            exp_we   = !(c >= 3 && c <= 5);
            exp_done = (c == 7);
            n_checks++;
            if (b_ale !== exp_ale || b_cle !== 1'b0 || b_we_l !== exp_we ||
                b_op_done !== exp_done || (exp_ale && b_io_out !== 8'h3A)) begin
                n_fail++;
                $display("FAIL addr c%0d: ale=%b cle=%b we_l=%b done=%b io=%h, required ale=%b cle=0 we_l=%b done=%b io=3A",
                         c, b_ale, b_cle, b_we_l, b_op_done, b_io_out, exp_ale, exp_we, exp_done);
            end
            @(posedge clk);
            #1;
        end
        $display("addr: ADDR 0x3A sequence checked");
    endtask

    task automatic test_rdata();
        logic exp_re, exp_done;
        wait_idle();
        io_in = 8'hA5;
        issue(3'd3, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) io_in = 8'h3C;
            exp_re   = (c != 1);
            exp_done = (c == 3);
            n_checks++;
            if (a_re_l !== exp_re || a_io_oe !== 1'b0 || a_we_l !== 1'b1 ||
                a_op_done !== exp_done || (c >= 3 && a_op_rdata !== 8'hA5)) begin
                n_fail++;
                $display("FAIL rdata c%0d: re_l=%b oe=%b we_l=%b done=%b rdata=%h, required re_l=%b oe=0 we_l=1 done=%b rdata=A5",
                         c, a_re_l, a_io_oe, a_we_l, a_op_done, a_op_rdata, exp_re, exp_done);
            end
            @(posedge clk);
            #1;
        end
        $display("rdata: read 0xA5 checked");
    endtask

    task automatic test_wait_rb();
        int c;
        int done_c;
        logic to;
        // rb_l rises 20 cycles after accept
        wait_idle();
        rb_l = 1'b0;
        issue(3'd4, 8'h00);
        c = 1; done_c = 0; to = 1'bx;
        while (c <= 300 && done_c == 0) begin
            if (c == 20) rb_l = 1'b1;
            if (a_op_done) begin
                done_c = c;
                to = a_op_timeout;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        n_checks++;
        if (done_c != 23 || to !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_rb_ready: done at cycle %0d timeout=%b, required cycle 23 timeout=0", done_c, to);
        end
        $display("wait_rb: ready after %0d cycles", done_c);

        // rb_l stuck low: timeout
        wait_idle();
        rb_l = 1'b0;
        issue(3'd4, 8'h00);
        c = 1; done_c = 0; to = 1'bx;
        while (c <= 300 && done_c == 0) begin
            if (a_op_done) begin
                done_c = c;
                to = a_op_timeout;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        n_checks++;
        if (done_c != 106 || to !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_rb_timeout: done at cycle %0d timeout=%b, required cycle 106 timeout=1", done_c, to);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (a_op_done !== 1'b0 || a_op_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: done=%b timeout=%b one cycle later, required 0 0", a_op_done, a_op_timeout);
        end
        rb_l = 1'b1;
        $display("wait_rb: timeout at cycle %0d", done_c);
    endtask

    task automatic test_invalid();
        logic exp_done;
        wait_idle();
        issue(3'd6, 8'h55);
        for (int c = 1; c <= 3; c++) begin
            exp_done = (c == 1);
            n_checks++;
            if (a_op_done !== exp_done || a_op_error !== exp_done || a_op_timeout !== 1'b0 ||
                a_we_l !== 1'b1 || a_re_l !== 1'b1 || a_cle !== 1'b0 || a_ale !== 1'b0 ||
                a_io_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid c%0d: done=%b err=%b to=%b we=%b re=%b cle=%b ale=%b oe=%b, required done=%b err=%b to=0 we=1 re=1 cle=0 ale=0 oe=0",
                         c, a_op_done, a_op_error, a_op_timeout, a_we_l, a_re_l, a_cle, a_ale,
                         a_io_oe, exp_done, exp_done);
            end
            @(posedge clk);
            #1;
        end
        $display("invalid: op_code 6 checked");
    endtask

    task automatic test_busy_ignore();
        logic exp_cle, exp_we, exp_done;
        wait_idle();
        issue(3'd0, 8'h11);
        // keep a different request pending while busy
        op_valid = 1'b1;
        op_code  = 3'd1;
        op_byte  = 8'h22;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) op_valid = 1'b0;
            exp_cle  = (c <= 3);
            exp_we   = (c != 2);
            exp_done = (c == 4);
            n_checks++;
            if (a_cle !== exp_cle || a_ale !== 1'b0 || a_we_l !== exp_we ||
                a_op_done !== exp_done || (exp_cle && a_io_out !== 8'h11)) begin
                n_fail++;
                $display("FAIL busy_ignore c%0d: cle=%b ale=%b we_l=%b done=%b io=%h, required cle=%b ale=0 we_l=%b done=%b io=11",
                         c, a_cle, a_ale, a_we_l, a_op_done, a_io_out, exp_cle, exp_we, exp_done);
            end
            @(posedge clk);
            #1;
        end
        $display("busy_ignore: request while busy ignored");
    endtask

    task automatic test_ce();
        @(negedge clk);
        ce_en = 1'b1;
        #1;
        n_checks++;
        if (a_ce_l !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_latency: ce_l=%b before edge, required 1", a_ce_l);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (a_ce_l !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_assert: ce_l=%b, required 0", a_ce_l);
        end
        @(negedge clk);
        ce_en = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (a_ce_l !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_release: ce_l=%b, required 1", a_ce_l);
        end
        $display("ce: follow checked");
    endtask

    task automatic test_reset_mid();
        wait_idle();
        issue(3'd0, 8'h77);
        @(posedge clk);
        #1;
        n_checks++;
        if (a_we_l !== 1'b0 || a_cle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: we_l=%b cle=%b in WE_LO, required 0 1", a_we_l, a_cle);
        end
        reset_l = 1'b0;
        #1;
        n_checks++;
        if (a_we_l !== 1'b1 || a_io_oe !== 1'b0 || a_cle !== 1'b0 || a_op_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pins: we_l=%b oe=%b cle=%b done=%b, required 1 0 0 0",
                     a_we_l, a_io_oe, a_cle, a_op_done);
        end
        @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (a_op_done !== 1'b0 || a_we_l !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_after c%0d: done=%b we_l=%b, required 0 1", c, a_op_done, a_we_l);
            end
        end
        n_checks++;
        if (a_op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: op_ready=%b, required 1", a_op_ready);
        end
        $display("reset_mid: abort during WE_LO checked");
    endtask

    initial begin
        #2;
        test_reset();
        test_cmd();
        test_addr();
        test_rdata();
        test_wait_rb();
        test_invalid();
        test_busy_ignore();
        test_ce();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
